lcd_controller: RTL and testbench

HD44780-compatible character-LCD controller in 8-bit bus mode. It sits directly downstream of `clockdivider` and uses its one-cycle `slow_clk` pulse, 1 ms at 50 MHz with div=50000, as the `tick` timebase for every LCD delay. After reset it runs the power-up wait and the fixed init sequence. It then accepts single character or command writes from a request/ready handshake and drives the LCD pins directly.

---
 rtl/lcd_controller.sv | 107 ++++++++++
 tb/tb_lcd_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_controller.sv
// lcd_controller: HD44780 8-bit bus controller with power-up init and request/ready writes,
// all LCD delays measured in ticks of an external timebase pulse.
module lcd_controller #(
    parameter int POWERUP_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);
    localparam int CW = $clog2(POWERUP_TICKS + 2);

    typedef enum logic [2:0] {PWR, SETUP, EHI, HOLD, IDLE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          settled;
    logic          user;
    logic          hold_two;
    logic          hold_end;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h01 : 8'h06;
    endfunction

    // clear/home (and 0x00/0x03) need the long hold
    always_comb begin
        hold_two = !lcd_rs && lcd_data[7:2] == 6'd0;
        hold_end = cnt == (hold_two ? CW'(1) : CW'(0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PWR;
            cnt       <= '0;
            idx       <= 2'd0;
            settled   <= 1'b0;
            user      <= 1'b0;
            ready     <= 1'b0;
            init_done <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            case (state)
                PWR: if (tick) begin
                    if (cnt == CW'(POWERUP_TICKS - 1)) begin
                        cnt      <= '0;
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_byte(2'd0);
                        settled  <= 1'b0;
                        state    <= SETUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // first cycle after entry ignores tick so the bus settles before E rises
                SETUP: begin
                    if (!settled) begin
                        settled <= 1'b1;
                    end else if (tick) begin
                        lcd_e <= 1'b1;
                        state <= EHI;
                    end
                end
                EHI: if (tick) begin
                    lcd_e <= 1'b0;
                    cnt   <= '0;
                    state <= HOLD;
                end
                HOLD: if (tick) begin
                    if (!hold_end) begin
                        cnt <= cnt + 1'b1;
                    end else if (user || idx == 2'd3) begin
                        ready     <= 1'b1;
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        idx      <= idx + 1'b1;
                        lcd_data <= init_byte(idx + 1'b1);
                        settled  <= 1'b0;
                        state    <= SETUP;
                    end
                end
                IDLE: if (req) begin
                    lcd_rs   <= rs_in;
                    lcd_data <= data_in;
                    ready    <= 1'b0;
                    user     <= 1'b1;
                    settled  <= 1'b0;
                    state    <= SETUP;
                end
                default: state <= PWR;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_controller.sv
// tb_lcd_controller: scoreboard bench for lcd_controller init sequence, user writes and reset.
module tb_lcd_controller;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       req = 1'b0;
    logic       rs_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    int nchk = 0, npass = 0, nticks = 0, npulse = 0, npush = 0, tphase = 0;
    int rise_tick = 0, fall_tick = 0;
    logic [8:0] sb[$];

    lcd_controller #(.POWERUP_TICKS(P)) dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .rs_in(rs_in), .data_in(data_in),
        .ready(ready), .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    // tick is high during every cycle whose phase is 9, i.e. every 10 clk
    initial forever begin
        @(posedge clk);
        #1;
        tphase = tphase == 9 ? 0 : tphase + 1;
        tick = tphase == 9;
    end

    initial forever begin
        @(posedge clk);
        if (tick) nticks++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic [8:0] v);
        sb.push_back(v);
        npush++;
    endtask

    // E-pulse monitor: pops the scoreboard on every rising E
    initial begin
        logic [8:0] bus, prev_bus, rise_bus;
        int stable, ew;
        logic e_prev;
        prev_bus = '0; rise_bus = '0; stable = 0; ew = 0; e_prev = 1'b0;
        forever begin
            @(negedge clk);
            bus = {lcd_rs, lcd_data};
            stable = bus == prev_bus ? stable + 1 : 1;
            prev_bus = bus;
            if (!rst) begin
                e_prev = 1'b0;
                ew = 0;
            end else begin
                if (lcd_e && !e_prev) begin
                    npulse++;
                    rise_tick = nticks;
                    rise_bus = bus;
                    ew = 0;
                    chk("setup_clks", stable >= 3, 1);
                    chk("rw_low", lcd_rw, 0);
                    if (sb.size() == 0) chk("e_extra", bus, 32'hffff_ffff);
                    else chk("e_bus", bus, sb.pop_front());
                end
                if (!lcd_e && e_prev) begin
                    fall_tick = nticks;
                    chk("e_width", ew, 10);
                    chk("e_bus_held", bus, rise_bus);
                end
                if (lcd_e) ew++;
                e_prev = lcd_e;
            end
        end
    end

    task automatic wait_ready(input int lim);
        for (int n = 0; n < lim && !ready; n++) @(negedge clk);
        chk("ready_rise", ready, 1);
    endtask

    task automatic wait_pulse(input int n);
        for (int i = 0; i < 300 && npulse < n; i++) @(negedge clk);
        chk("pulse_seen", npulse >= n, 1);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 12 && tphase != p; i++) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        chk("rst_e", lcd_e, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_flags", {ready, init_done, lcd_rs, lcd_rw}, 0);
        npush -= sb.size();
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic run_init(input bit abort);
        int t0, b;
        @(posedge clk);
        #2 rst = 1'b1;
        t0 = nticks;
        b = npulse;
        push(9'h038); push(9'h00C); push(9'h001); push(9'h006);
        @(negedge clk);
        wait_pulse(b + 1);
        chk("first_e_tick", rise_tick - t0, P + 1);
        if (abort) begin
            wait_pulse(b + 2);
            chk("abort_e_high", lcd_e, 1);
            @(posedge clk);
            #2;
            apply_reset();
        end else begin
            wait_ready(400);
            chk("init_ticks", nticks - t0, P + 13);
            chk("init_done", init_done, 1);
            chk("init_pulses", npulse - b, 4);
            chk("init_sb_drain", sb.size(), 0);
        end
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d, input int ph,
                            input int lat, input int erise, input bit spam);
        int ta;
        wait_ready(600);
        wait_phase(ph);
        req = 1'b1; rs_in = rs; data_in = d;
        push({rs, d});
        @(negedge clk);
        req = 1'b0;
        ta = nticks;
        chk("acc_ready", ready, 0);
        chk("acc_bus", {lcd_rs, lcd_data}, {rs, d});
        if (ph == 8) begin
            @(negedge clk);
            chk("ign_tick_e", lcd_e, 0);
        end
        if (spam) begin
            req = 1'b1; rs_in = 1'b0; data_in = 8'h55;
            repeat (20) @(negedge clk);
            req = 1'b0;
            chk("busy_bus", {lcd_rs, lcd_data}, {rs, d});
            chk("busy_ready", ready, 0);
        end
        wait_ready(100);
        chk("latency", nticks - ta, lat);
        chk("e_rise_tick", rise_tick - ta, erise);
        chk("e_fall_tick", fall_tick - ta, erise + 1);
    endtask

    initial begin
        @(negedge clk);
        apply_reset();
        run_init(1'b0);
        do_write(1'b1, 8'h41, 3, 3, 1, 1'b1);
        do_write(1'b0, 8'h01, 3, 4, 1, 1'b0);
        do_write(1'b0, 8'h80, 3, 3, 1, 1'b0);
        do_write(1'b1, 8'h42, 8, 4, 2, 1'b0);
        do_write(1'b0, 8'h02, 5, 4, 1, 1'b0);
        @(negedge clk);
        apply_reset();
        run_init(1'b1);
        run_init(1'b0);
        do_write(1'b1, 8'h43, 0, 3, 1, 1'b0);
        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("pulse_count", npulse, npush);
        chk("init_hold", init_done, 1);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
